// File: rtl/falling_sand_pkg.sv
// Shared types and constants for the falling-sand VRAM write path.
package falling_sand_pkg;

  localparam int VRAM_ADDR_W = 18;  // $clog2(640*400)
  localparam int VRAM_DATA_W = 2;

  // Cell encodings stored in VRAM
  localparam logic [VRAM_DATA_W-1:0] EMPTY = 2'b00;
  localparam logic [VRAM_DATA_W-1:0] SAND  = 2'b01;
  localparam logic [VRAM_DATA_W-1:0] WALL  = 2'b10;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_GST,
    GRANT_MPD
  } grant_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_wr_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO of VRAM writes. Push is ignored when full, pop is
// ignored when empty. Head is read from registered state only, so an entry
// pushed this cycle can be popped next cycle at the earliest.
module vram_wr_fifo
  import falling_sand_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  vram_wr_t      push_data,
  input  logic          pop,
  output vram_wr_t      head,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);

  vram_wr_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage: no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; count tracks occupancy (push+pop leaves it unchanged)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates the single VRAM write port between the game-state controller
// (valid/ready) and the mouse pixel drawer (fire-and-forget, FIFO-buffered).
// GST gets priority, but only for a bounded burst while MPD writes are waiting.
module vram_write_arbiter
  import falling_sand_pkg::*;
#(
  parameter int ADDR_WIDTH    = VRAM_ADDR_W,
  parameter int DATA_WIDTH    = VRAM_DATA_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_GST_BURST = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  gst_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] gst_wr_address_i,
  input  logic [DATA_WIDTH-1:0] gst_wr_data_i,
  output logic                  gst_ready_o,
  input  logic                  mpd_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] mpd_wr_address_i,
  input  logic [DATA_WIDTH-1:0] mpd_wr_data_i,
  output logic                  mpd_ready_o,
  output logic                  mpd_overflow_o,
  output logic                  vram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o
);

  localparam int BW = $clog2(MAX_GST_BURST + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  grant_t          winner, last_grant;
  logic [BW-1:0]   burst_cnt, burst_nxt;
  vram_wr_t        gst_wr, mpd_wr, mpd_head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            mpd_push;

  assign gst_wr = '{addr: gst_wr_address_i, data: gst_wr_data_i};
  assign mpd_wr = '{addr: mpd_wr_address_i, data: mpd_wr_data_i};

  // Ready comes from registered occupancy: a same-cycle pop does not free a slot
  assign mpd_ready_o = (fifo_count < CW'(FIFO_DEPTH));
  assign mpd_push    = mpd_wr_en_i && mpd_ready_o;
  assign gst_ready_o = (winner == GRANT_GST);

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .push      (mpd_push),
    .push_data (mpd_wr),
    .pop       (winner == GRANT_MPD),
    .head      (mpd_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Grant decision: GST first, unless MPD is full or GST has used its burst
  always_comb begin
    winner    = GRANT_NONE;
    burst_nxt = burst_cnt;
    if (fifo_empty) begin
      burst_nxt = '0;
      if (gst_wr_en_i) winner = GRANT_GST;
    end else if (gst_wr_en_i && !fifo_full && (burst_cnt < BW'(MAX_GST_BURST))) begin
      // Increment is gated by the limit, so the counter never wraps
      winner    = GRANT_GST;
      burst_nxt = burst_cnt + BW'(1);
    end else begin
      winner    = GRANT_MPD;
      burst_nxt = '0;
    end
  end

  // Arbitration state and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      burst_cnt      <= '0;
      last_grant     <= GRANT_NONE;
      mpd_overflow_o <= 1'b0;
    end else begin
      burst_cnt  <= burst_nxt;
      last_grant <= winner;
      if (mpd_wr_en_i && !mpd_ready_o) mpd_overflow_o <= 1'b1;
    end
  end

  // Output write word: load the winner's address/data, hold when idle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vram_wr_address_o <= '0;
      vram_wr_data_o    <= '0;
    end else begin
      case (winner)
        GRANT_GST: begin
          vram_wr_address_o <= gst_wr.addr;
          vram_wr_data_o    <= gst_wr.data;
        end
        GRANT_MPD: begin
          vram_wr_address_o <= mpd_head.addr;
          vram_wr_data_o    <= mpd_head.data;
        end
        default: ;
      endcase
    end
  end

  // Write enable is a decode of the registered grant
  assign vram_wr_en_o = (last_grant != GRANT_NONE);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed + randomized bench for vram_write_arbiter with a queue-based model.
module tb_vram_write_arbiter;

  localparam int AW    = 18;
  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int MAXB  = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          gst_wr_en_i = 1'b0;
  logic [AW-1:0] gst_wr_address_i = '0;
  logic [DW-1:0] gst_wr_data_i = '0;
  logic          gst_ready_o;
  logic          mpd_wr_en_i = 1'b0;
  logic [AW-1:0] mpd_wr_address_i = '0;
  logic [DW-1:0] mpd_wr_data_i = '0;
  logic          mpd_ready_o;
  logic          mpd_overflow_o;
  logic          vram_wr_en_o;
  logic [AW-1:0] vram_wr_address_o;
  logic [DW-1:0] vram_wr_data_o;

  always #5 clk = ~clk;

  vram_write_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_GST_BURST(MAXB)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .gst_wr_en_i       (gst_wr_en_i),
    .gst_wr_address_i  (gst_wr_address_i),
    .gst_wr_data_i     (gst_wr_data_i),
    .gst_ready_o       (gst_ready_o),
    .mpd_wr_en_i       (mpd_wr_en_i),
    .mpd_wr_address_i  (mpd_wr_address_i),
    .mpd_wr_data_i     (mpd_wr_data_i),
    .mpd_ready_o       (mpd_ready_o),
    .mpd_overflow_o    (mpd_overflow_o),
    .vram_wr_en_o      (vram_wr_en_o),
    .vram_wr_address_o (vram_wr_address_o),
    .vram_wr_data_o    (vram_wr_data_o)
  );

  // Reference model: MPD backlog as a queue of pending writes, burst as an int
  typedef struct { int a; int d; } wr_t;
  wr_t q[$];
  int  burst;
  int  ovf;
  int  exp_en, exp_a, exp_d;
  int  last_w;   // 0 none, 1 gst, 2 mpd
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    burst = 0; ovf = 0; exp_en = 0; exp_a = 0; exp_d = 0; last_w = 0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registers
  task automatic step(input int ge, input int ga, input int gd,
                      input int me, input int ma, input int md);
    int  n;
    bit  full;
    wr_t e;
    gst_wr_en_i      = ge[0];
    gst_wr_address_i = AW'(ga);
    gst_wr_data_i    = DW'(gd);
    mpd_wr_en_i      = me[0];
    mpd_wr_address_i = AW'(ma);
    mpd_wr_data_i    = DW'(md);
    #1;
    n    = q.size();
    full = (n == DEPTH);
    if (n == 0)                          last_w = ge ? 1 : 0;
    else if (ge != 0 && !full && burst < MAXB) last_w = 1;
    else                                 last_w = 2;
    check("gst_ready", 32'(gst_ready_o), 32'(last_w == 1));
    check("mpd_ready", 32'(mpd_ready_o), 32'(!full));
    if (last_w == 1) begin
      exp_en = 1; exp_a = ga % (1 << AW); exp_d = gd % (1 << DW);
      burst  = (n == 0) ? 0 : burst + 1;
    end else if (last_w == 2) begin
      e = q.pop_front();
      exp_en = 1; exp_a = e.a; exp_d = e.d;
      burst  = 0;
    end else begin
      exp_en = 0; burst = 0;
    end
    if (me != 0) begin
      if (!full) q.push_back('{a: ma % (1 << AW), d: md % (1 << DW)});
      else       ovf = 1;
    end
    @(posedge clk); #1;
    check("vram_en", 32'(vram_wr_en_o), 32'(exp_en));
    if (exp_en != 0) begin
      check("vram_addr", 32'(vram_wr_address_o), 32'(exp_a));
      check("vram_data", 32'(vram_wr_data_o), 32'(exp_d));
    end
    check("overflow", 32'(mpd_overflow_o), 32'(ovf));
  endtask

  task automatic do_reset(input int cycles);
    reset_i = 1'b1; gst_wr_en_i = 1'b0; mpd_wr_en_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_clear();
    check("rst_en",    32'(vram_wr_en_o), 32'(0));
    check("rst_addr",  32'(vram_wr_address_o), 32'(0));
    check("rst_data",  32'(vram_wr_data_o), 32'(0));
    check("rst_ready", 32'(mpd_ready_o), 32'(1));
    check("rst_ovf",   32'(mpd_overflow_o), 32'(0));
    check("rst_gst",   32'(gst_ready_o), 32'(0));
    reset_i = 1'b0;
  endtask

  initial begin
    int g, cnt, seen, guard, gp, ga, gd, me, p;

    // 1: reset held 3 cycles
    do_reset(3);

    // 2: GST streams 0..9 with FIFO empty
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, i, 1, 0, 0, 0);
      if (last_w == 1) cnt++;
    end
    check("t2_gst_grants", 32'(cnt), 32'(10));
    step(0, 0, 0, 0, 0, 0);

    // 3: MPD-only pushes 100..102, writes appear two cycles after each push
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 100 + i, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // 4: one MPD push during a GST stream lets exactly MAXB GST grants through
    g = 1000; cnt = 0; seen = 0; guard = 0;
    step(1, g, 1, 1, 500, 2);
    if (last_w == 1) g++;
    while (seen == 0 && guard < 40) begin
      step(1, g, 1, 0, 0, 0);
      if (last_w == 1) begin g++; cnt++; end
      else if (last_w == 2) seen = 1;
      guard++;
    end
    check("t4_mpd_seen", 32'(seen), 32'(1));
    check("t4_gst_burst", 32'(cnt), 32'(MAXB));
    for (int i = 0; i < 4; i++) begin
      step(1, g, 1, 0, 0, 0);
      if (last_w == 1) g++;
    end

    // 5: five back-to-back MPD pushes during GST stream, fifth dropped
    for (int i = 0; i < 5; i++) begin
      step(1, g, 1, 1, 600 + i, 2);
      if (last_w == 1) g++;
    end
    check("t5_overflow", 32'(mpd_overflow_o), 32'(1));
    for (int i = 0; i < 40; i++) begin
      step(1, g, 1, 0, 0, 0);
      if (last_w == 1) g++;
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

    // 6: three entries queued, single-cycle reset discards them
    for (int i = 0; i < 3; i++) begin
      step(1, g, 1, 1, 700 + i, 3);
      if (last_w == 1) g++;
    end
    check("t6_queued", 32'(q.size()), 32'(3));
    do_reset(1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

    // Randomized traffic at several MPD densities
    for (int blk = 0; blk < 4; blk++) begin
      p  = 10 + 27 * blk;
      gp = 0; ga = 0; gd = 0;
      for (int c = 0; c < 150; c++) begin
        if (gp == 0 && $urandom_range(0, 99) < 70) begin
          gp = 1;
          ga = int'($urandom_range(0, (1 << AW) - 1));
          gd = int'($urandom_range(0, 3));
        end
        me = ($urandom_range(0, 99) < p) ? 1 : 0;
        step(gp, ga, gd, me, int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, 3)));
        if (last_w == 1) gp = 0;
      end
      do_reset(1 + blk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
